pipelined_inner_product_checker: RTL and testbench

PIPELINED_INNER_PRODUCT_CHECKER -- requirements
Module: pipelined_inner_product_checker

---
 rtl/pipelined_inner_product_pkg.sv | 23 ++
 rtl/pipelined_inner_product_checker_pipe_delay.sv | 52 +++++
 rtl/pipelined_inner_product_checker.sv | 132 +++++++++++++
 tb/tb_pipelined_inner_product_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_inner_product_pkg.sv
// Shared defaults, FSM state type and counter type for the inner-product checker.
package pipelined_inner_product_pkg;

  localparam int DATA_W_DEF  = 9;
  localparam int OUT_W_DEF   = 8;
  localparam int LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHECK,
    ST_FAIL
  } state_t;

  typedef logic [15:0] cnt_t;

  localparam cnt_t CNT_MAX = 16'hFFFF;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : cnt_t'(v + 16'd1);
  endfunction

endpackage

// File: rtl/pipelined_inner_product_checker_pipe_delay.sv
// Fixed-depth delay line of {valid, data}; valid bits are reset and flushable.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pre_valid_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
      end
      valid_q[0] <= valid_i;
    end
  end

  // Data needs no reset: it is only consumed when its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      data_q[i] <= data_q[i-1];
    end
    data_q[0] <= data_i;
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

  // Valid bit that will sit at the tap on the next cycle.
  generate
    if (DEPTH == 1) begin : g_pre_direct
      assign pre_valid_o = valid_i;
    end else begin : g_pre_stage
      assign pre_valid_o = valid_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/pipelined_inner_product_checker.sv
// Checks a multiplier pipeline: delays the expected product by LATENCY cycles and
// compares it with the pipeline result, tracking counts and the first mismatch.
module pipelined_inner_product_checker
  import pipelined_inner_product_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] inp1,
  input  logic [DATA_W-1:0] inp2,
  input  logic [OUT_W-1:0]  dut_outp,
  output logic              pass,
  output logic              fail,
  output logic [15:0]       chk_count,
  output logic [15:0]       err_count,
  output logic [OUT_W-1:0]  first_exp,
  output logic [OUT_W-1:0]  first_act,
  output logic [15:0]       first_idx
);

  logic [OUT_W-1:0] exp_now;
  logic             tap_valid;
  logic [OUT_W-1:0] tap_exp;
  logic             pre_valid;
  logic             do_cmp;
  logic             mismatch;

  state_t           state_q, state_d;
  cnt_t             chk_q, chk_d;
  cnt_t             err_q, err_d;
  cnt_t             fidx_q, fidx_d;
  logic [OUT_W-1:0] fexp_q, fexp_d;
  logic [OUT_W-1:0] fact_q, fact_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  // Full-width product, then keep the low OUT_W bits.
  assign exp_now = OUT_W'({{DATA_W{1'b0}}, inp1} * {{DATA_W{1'b0}}, inp2});

  pipe_delay #(
    .WIDTH (OUT_W),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clear),
    .valid_i     (in_valid),
    .data_i      (exp_now),
    .valid_o     (tap_valid),
    .data_o      (tap_exp),
    .pre_valid_o (pre_valid)
  );

  assign do_cmp   = tap_valid && ((state_q == ST_CHECK) || (state_q == ST_FAIL));
  assign mismatch = do_cmp && (dut_outp != tap_exp);

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;

    case (state_q)
      ST_IDLE:  if (in_valid) state_d = (LATENCY == 1) ? ST_CHECK : ST_FILL;
      ST_FILL:  if (pre_valid) state_d = ST_CHECK;
      ST_CHECK: if (mismatch) state_d = ST_FAIL;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase

    if (do_cmp) chk_d = sat_inc(chk_q);
    if (mismatch) begin
      err_d = sat_inc(err_q);
      // Only the mismatch that leaves CHECK is recorded as the first one.
      if (state_q == ST_CHECK) begin
        fexp_d = tap_exp;
        fact_d = dut_outp;
        fidx_d = chk_q;
      end
    end

    if (clear) begin
      state_d = ST_IDLE;
      chk_d   = '0;
      err_d   = '0;
      fidx_d  = '0;
      fexp_d  = '0;
      fact_d  = '0;
    end

    pass_d = (state_d == ST_CHECK);
    fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign pass      = pass_q;
  assign fail      = fail_q;
  assign chk_count = chk_q;
  assign err_count = err_q;
  assign first_exp = fexp_q;
  assign first_act = fact_q;
  assign first_idx = fidx_q;

endmodule

// File: tb/tb_pipelined_inner_product_checker.sv
// Bench for the inner-product checker: a directed vector table, then hand sequences
// and random traffic compared against a queue-based reference model.
module tb_pipelined_inner_product_checker;
  import pipelined_inner_product_pkg::*;

  localparam int DW = 9;
  localparam int OW = 8;
  localparam int L  = LATENCY_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] inp1 = '0;
  logic [DW-1:0] inp2 = '0;
  logic [OW-1:0] dut_outp = '0;
  logic          pass;
  logic          fail;
  logic [15:0]   chk_count;
  logic [15:0]   err_count;
  logic [OW-1:0] first_exp;
  logic [OW-1:0] first_act;
  logic [15:0]   first_idx;

  always #5 clk = ~clk;

  pipelined_inner_product_checker #(
    .DATA_W  (DW),
    .OUT_W   (OW),
    .LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .inp1      (inp1),
    .inp2      (inp2),
    .dut_outp  (dut_outp),
    .pass      (pass),
    .fail      (fail),
    .chk_count (chk_count),
    .err_count (err_count),
    .first_exp (first_exp),
    .first_act (first_act),
    .first_idx (first_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Vector table: inputs plus hand-derived expected outputs after that cycle's edge.
  typedef struct {
    bit v; int a; int b; bit ovr; int dv; bit clr;
    int chk; int err; bit ps; bit fl; int fexp; int fact; int fidx;
  } row_t;

  row_t tbl[16];
  int   prod_hist[16];

  // Reference model: results owed by the pipeline, oldest first.
  typedef struct { bit v; int e; } ent_t;
  ent_t m_q[$];
  int   m_chk, m_err, m_fexp, m_fact, m_fidx;
  bit   m_started;
  int   cyc = 0;

  task automatic model_flush();
    m_q.delete();
    for (int i = 0; i < L; i++) m_q.push_back('{1'b0, 0});
    m_chk = 0; m_err = 0; m_fexp = 0; m_fact = 0; m_fidx = 0;
    m_started = 1'b0;
  endtask

  task automatic model_edge(input bit clr, input bit v, input int a, input int b, input int d);
    ent_t t;
    if (clr) begin
      model_flush();
      return;
    end
    t = m_q.pop_front();
    if (t.v) begin
      if (d != t.e) begin
        if (m_err == 0) begin
          m_fexp = t.e; m_fact = d; m_fidx = m_chk;
        end
        if (m_err < 65535) m_err++;
      end
      if (m_chk < 65535) m_chk++;
    end
    m_q.push_back('{v, (a * b) % 256});
    if (m_q[0].v) m_started = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".chk_count"}, int'(chk_count), m_chk);
    check({tag, ".err_count"}, int'(err_count), m_err);
    check({tag, ".pass"}, int'(pass), int'(m_started && m_err == 0));
    check({tag, ".fail"}, int'(fail), int'(m_err > 0));
    check({tag, ".first_exp"}, int'(first_exp), m_fexp);
    check({tag, ".first_act"}, int'(first_act), m_fact);
    check({tag, ".first_idx"}, int'(first_idx), m_fidx);
  endtask

  // One model-checked cycle; dut_outp is the correct result unless corrupted.
  task automatic mcycle(input bit v, input int a, input int b, input bit corrupt, input bit clr);
    int d;
    in_valid = v; inp1 = DW'(a); inp2 = DW'(b); clear = clr;
    d = m_q[0].v ? m_q[0].e : int'($urandom_range(0, 255));
    if (corrupt) d = (d + 1 + int'($urandom_range(0, 254))) % 256;
    dut_outp = OW'(d);
    @(posedge clk);
    model_edge(clr, v, a, b, d);
    #1;
    $display("cyc %0d v=%0d a=%0d b=%0d d=%0d clr=%0d -> chk=%0d err=%0d pass=%0d fail=%0d",
             cyc, v, a, b, d, clr, chk_count, err_count, pass, fail);
    cyc++;
    check_all($sformatf("cyc%0d", cyc));
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic rst_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".pass"}, int'(pass), 0);
    check({tag, ".fail"}, int'(fail), 0);
    check({tag, ".chk_count"}, int'(chk_count), 0);
    check({tag, ".err_count"}, int'(err_count), 0);
    check({tag, ".first_exp"}, int'(first_exp), 0);
    check({tag, ".first_act"}, int'(first_act), 0);
    check({tag, ".first_idx"}, int'(first_idx), 0);
    model_flush();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int d;

    //          v  a   b  ovr dv clr  chk err ps fl fexp fact fidx
    tbl[0]  = '{1, 0,  0,  0, 0, 0,    0, 0, 0, 0,  0,  0, 0};
    tbl[1]  = '{1, 1,  1,  0, 0, 0,    0, 0, 0, 0,  0,  0, 0};
    tbl[2]  = '{1, 2,  2,  0, 0, 0,    0, 0, 1, 0,  0,  0, 0};
    tbl[3]  = '{1, 3,  3,  0, 0, 0,    1, 0, 1, 0,  0,  0, 0};
    tbl[4]  = '{1, 4,  4,  0, 0, 0,    2, 0, 1, 0,  0,  0, 0};
    tbl[5]  = '{1, 5,  5,  0, 0, 0,    3, 0, 1, 0,  0,  0, 0};
    tbl[6]  = '{1, 6,  6,  0, 0, 0,    4, 0, 1, 0,  0,  0, 0};
    tbl[7]  = '{1, 7,  7,  0, 0, 0,    5, 0, 1, 0,  0,  0, 0};
    tbl[8]  = '{1, 8,  8,  0, 0, 0,    6, 0, 1, 0,  0,  0, 0};
    tbl[9]  = '{1, 9,  9,  0, 0, 0,    7, 0, 1, 0,  0,  0, 0};
    tbl[10] = '{1, 10, 10, 1, 50, 0,   8, 1, 0, 1, 49, 50, 7};
    tbl[11] = '{1, 11, 11, 0, 0, 0,    9, 1, 0, 1, 49, 50, 7};
    tbl[12] = '{1, 12, 12, 0, 0, 0,   10, 1, 0, 1, 49, 50, 7};
    tbl[13] = '{1, 13, 13, 1, 0, 0,   11, 2, 0, 1, 49, 50, 7};
    tbl[14] = '{1, 14, 14, 1, 0, 1,    0, 0, 0, 0,  0,  0, 0};
    tbl[15] = '{1, 2,  2,  0, 0, 0,    0, 0, 0, 0,  0,  0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset.pass", int'(pass), 0);
    check("reset.fail", int'(fail), 0);
    check("reset.chk_count", int'(chk_count), 0);
    check("reset.err_count", int'(err_count), 0);
    check("reset.first_idx", int'(first_idx), 0);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      prod_hist[r] = (tbl[r].a * tbl[r].b) % 256;
      d = (r >= L) ? prod_hist[r-L] : 0;
      if (tbl[r].ovr) d = tbl[r].dv;
      in_valid = tbl[r].v; inp1 = DW'(tbl[r].a); inp2 = DW'(tbl[r].b);
      dut_outp = OW'(d); clear = tbl[r].clr;
      @(posedge clk);
      #1;
      $display("row %0d v=%0d a=%0d d=%0d clr=%0d -> chk=%0d err=%0d pass=%0d fail=%0d fexp=%0d fact=%0d fidx=%0d",
               r, tbl[r].v, tbl[r].a, d, tbl[r].clr, chk_count, err_count, pass, fail,
               first_exp, first_act, first_idx);
      check($sformatf("row%0d.chk_count", r), int'(chk_count), tbl[r].chk);
      check($sformatf("row%0d.err_count", r), int'(err_count), tbl[r].err);
      check($sformatf("row%0d.pass", r), int'(pass), int'(tbl[r].ps));
      check($sformatf("row%0d.fail", r), int'(fail), int'(tbl[r].fl));
      check($sformatf("row%0d.first_exp", r), int'(first_exp), tbl[r].fexp);
      check($sformatf("row%0d.first_act", r), int'(first_act), tbl[r].fact);
      check($sformatf("row%0d.first_idx", r), int'(first_idx), tbl[r].fidx);
    end
    in_valid = 1'b0; clear = 1'b0;

    rst_pulse("rst_after_table");

    // Truncation corners, then a stream with a two-cycle bubble.
    mcycle(1, 16, 16, 0, 0);
    mcycle(1, 17, 17, 0, 0);
    for (int i = 0; i < 5; i++) mcycle(1, i, i, 0, 0);
    mcycle(0, 0, 0, 0, 0);
    mcycle(0, 0, 0, 0, 0);
    for (int i = 5; i < 12; i++) mcycle(1, i, i, 0, 0);

    rst_pulse("rst_mid_check");
    mcycle(1, 5, 5, 0, 0);
    rst_pulse("rst_mid_fill");

    mcycle(1, 6, 6, 0, 0);
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      mcycle(0, 0, 0, 0, 0);
      if (chk_count == 16'd1 && lat < 0) lat = n;
    end
    check("first_compare_latency", lat, L);

    // Mismatch then clear on a mismatching tap cycle.
    for (int i = 0; i < 6; i++) mcycle(1, i + 30, i + 3, (i == 4), 0);
    mcycle(1, 40, 41, 1, 1);
    check("clear_in_fail.fail", int'(fail), 0);
    check("clear_in_fail.err_count", int'(err_count), 0);

    for (int i = 0; i < 400; i++) begin
      mcycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
             ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
